// File: rtl/fp_accum_seq_pkg.sv
// -----------------------------------------------------------------------------
// fp_accum_seq_pkg
// Shared fp24 definitions for the accumulating reducer:
//   - fp24 field positions (sign[23], exp[22:15], mant[14:0])
//   - reduction-op encoding used on the command port
//   - reducer FSM state encoding
//   - fp_std operation codes and an ordered-compare helper
// -----------------------------------------------------------------------------
package fp_accum_seq_pkg;

    localparam int FP_W        = 24;
    localparam int FP_SIGN     = 23;
    localparam int FP_EXP_MSB  = 22;
    localparam int FP_EXP_LSB  = 15;
    localparam int FP_MANT_MSB = 14;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 15;

    typedef enum logic [1:0] {
        RED_SUM     = 2'b00,
        RED_MAX     = 2'b01,
        RED_MIN     = 2'b10,
        RED_SUM_ALT = 2'b11
    } red_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FIRST = 2'b01,
        ST_ACCUM = 2'b10,
        ST_DONE  = 2'b11
    } acc_state_e;

    localparam logic [2:0] FPOP_ADD = 3'd0;
    localparam logic [2:0] FPOP_MAX = 3'd1;
    localparam logic [2:0] FPOP_MIN = 3'd2;

    // Sign-magnitude ordering: a > b. +0 is treated as greater than -0.
    function automatic logic fp_gt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        logic res;
        if (a[FP_SIGN] != b[FP_SIGN]) begin
            res = ~a[FP_SIGN];
        end else if (!a[FP_SIGN]) begin
            res = (a[FP_EXP_MSB:0] > b[FP_EXP_MSB:0]);
        end else begin
            res = (a[FP_EXP_MSB:0] < b[FP_EXP_MSB:0]);
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_accum_seq_std.sv
// -----------------------------------------------------------------------------
// fp_std
// Combinational fp24 arithmetic unit: add, max, min.
// Add truncates alignment and normalisation shifts; exponent 0 is zero (no
// denormals), no NaN/Inf handling, exponent overflow wraps.
// Ports:
//   a_i   [WIDTH-1:0]  operand A (accumulator side)
//   b_i   [WIDTH-1:0]  operand B (incoming element)
//   op_i  [2:0]        0 add, 1 max, 2 min, others add
//   res_o [WIDTH-1:0]  result
// -----------------------------------------------------------------------------
module fp_std
    import fp_accum_seq_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] res_o
);

    logic [FP_W-1:0]     big, sml, add_res;
    logic [FP_EXP_W-1:0] e_big, e_sml, shamt;
    logic [15:0]         m_big, m_sml, m_sml_sh, diff, norm;
    logic [16:0]         sum;
    logic [4:0]          lz;
    logic                found;

    always_comb begin
        big      = a_i[FP_W-1:0];
        sml      = b_i[FP_W-1:0];
        add_res  = '0;
        sum      = '0;
        diff     = '0;
        norm     = '0;
        lz       = '0;
        found    = 1'b0;
        m_sml_sh = '0;

        // Larger magnitude first, so the alignment shift is always non-negative.
        if (b_i[FP_EXP_MSB:0] > a_i[FP_EXP_MSB:0]) begin
            big = b_i[FP_W-1:0];
            sml = a_i[FP_W-1:0];
        end

        e_big = big[FP_EXP_MSB:FP_EXP_LSB];
        e_sml = sml[FP_EXP_MSB:FP_EXP_LSB];
        m_big = {|e_big, big[FP_MANT_MSB:0]};
        m_sml = {|e_sml, sml[FP_MANT_MSB:0]};
        shamt = e_big - e_sml;

        if (shamt < 8'd16) begin
            m_sml_sh = m_sml >> shamt;
        end

        if (e_big == '0) begin
            add_res = '0;
        end else if (big[FP_SIGN] == sml[FP_SIGN]) begin
            sum = {1'b0, m_big} + {1'b0, m_sml_sh};
            if (sum[16]) begin
                add_res = {big[FP_SIGN], e_big + 8'd1, sum[15:1]};
            end else begin
                add_res = {big[FP_SIGN], e_big, sum[14:0]};
            end
        end else begin
            diff = m_big - m_sml_sh;
            for (int i = 15; i >= 0; i--) begin
                if (!found && diff[i]) begin
                    lz    = 5'(15 - i);
                    found = 1'b1;
                end
            end
            norm = diff << lz;
            // Cancellation to zero or normalising below exponent 1 flushes to zero.
            if (found && (e_big > {3'b000, lz})) begin
                add_res = {big[FP_SIGN], e_big - {3'b000, lz}, norm[14:0]};
            end
        end

        case (op_i)
            FPOP_MAX: res_o = fp_gt(a_i[FP_W-1:0], b_i[FP_W-1:0]) ? a_i : b_i;
            FPOP_MIN: res_o = fp_gt(a_i[FP_W-1:0], b_i[FP_W-1:0]) ? b_i : a_i;
            default:  res_o = WIDTH'(add_res);
        endcase
    end

endmodule

// File: rtl/fp_accum_seq.sv
// -----------------------------------------------------------------------------
// fp_accum_seq
// Sequential fp24 reducer: accepts a command (op, length), then that many
// elements, and returns the sum / max / min through a ready/valid result port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a command, start_ready_o high
//   ST_FIRST | waiting for the first element, loaded without arithmetic
//   ST_ACCUM | folding further elements through fp_std, one per cycle
//   ST_DONE  | result held on out_data_o until out_ready_i
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   flush_i                          synchronous abort (beats all handshakes)
//   start_valid_i/start_ready_o      command handshake
//   start_op_i[1:0], start_len_i[4:0] command: 00 sum, 01 max, 10 min, 11 sum
//   in_valid_i/in_ready_o, in_data_i element stream
//   out_valid_o/out_ready_i, out_data_o result
//   busy_o                           high outside ST_IDLE
// -----------------------------------------------------------------------------
module fp_accum_seq
    import fp_accum_seq_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int MAX_LEN = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [1:0]       start_op_i,
    input  logic [4:0]       start_len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o
);

    localparam int            CW      = $clog2(MAX_LEN) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    acc_state_e       state_q, state_d;
    red_op_e          op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    len_clamped;
    logic [WIDTH-1:0] fp_res;
    logic             start_ready_q, in_ready_q, out_valid_q, busy_q;
    logic             in_fire;

    fp_std #(.WIDTH(WIDTH)) u_fp_std (
        .a_i   (acc_q),
        .b_i   (in_data_i),
        .op_i  ({1'b0, op_q}),
        .res_o (fp_res)
    );

    assign len_clamped = (int'(start_len_i) > MAX_LEN) ? MAX_CNT : CW'(start_len_i);
    assign in_fire     = in_valid_i && in_ready_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid_i) begin
                        op_d = red_op_e'(start_op_i);
                        if (len_clamped == '0) begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = len_clamped;
                            state_d = ST_FIRST;
                        end
                    end
                end
                ST_FIRST, ST_ACCUM: begin
                    if (in_fire && (cnt_q != '0)) begin
                        acc_d   = (state_q == ST_FIRST) ? in_data_i : fp_res;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake flags are registered from the next state so they change
    // together with state_q and never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            op_q          <= RED_SUM;
            acc_q         <= '0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            start_ready_q <= (state_d == ST_IDLE);
            in_ready_q    <= (state_d == ST_FIRST) || (state_d == ST_ACCUM);
            out_valid_q   <= (state_d == ST_DONE);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign start_ready_o = start_ready_q;
    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign busy_o        = busy_q;
    assign out_data_o    = acc_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_accum_seq
// Directed bench for fp_accum_seq. Inputs change and outputs are sampled on
// the falling edge; the DUT samples on the rising edge.
// -----------------------------------------------------------------------------
module tb_fp_accum_seq;

    localparam logic [23:0] FP_ONE   = 24'h3F8000;  //  1.0
    localparam logic [23:0] FP_TWO   = 24'h400000;  //  2.0
    localparam logic [23:0] FP_THREE = 24'h404000;  //  3.0
    localparam logic [23:0] FP_FOUR  = 24'h408000;  //  4.0
    localparam logic [23:0] FP_M3    = 24'hC04000;  // -3.0
    localparam logic [23:0] FP_16    = 24'h418000;  // 16.0

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        start_valid_i;
    logic        start_ready_o;
    logic [1:0]  start_op_i;
    logic [4:0]  start_len_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [23:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [23:0] out_data_o;
    logic        busy_o;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc;

    fp_accum_seq #(.WIDTH(24), .MAX_LEN(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .start_op_i    (start_op_i),
        .start_len_i   (start_len_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic start_cmd(input logic [1:0] op, input logic [4:0] len);
        chk("idle start_ready", 32'(start_ready_o), 32'd1);
        chk("idle in_ready", 32'(in_ready_o), 32'd0);
        start_valid_i = 1'b1;
        start_op_i    = op;
        start_len_i   = len;
        @(negedge clk_i);
        start_valid_i = 1'b0;
    endtask

    task automatic push(input logic [23:0] d);
        chk("push in_ready", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        in_data_i  = d;
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic take();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        chk("after take out_valid", 32'(out_valid_o), 32'd0);
        chk("after take start_ready", 32'(start_ready_o), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " start_ready"}, 32'(start_ready_o), 32'd1);
        chk({tag, " in_ready"}, 32'(in_ready_o), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, " out_data"}, 32'(out_data_o), 32'd0);
        chk({tag, " busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        start_valid_i = 1'b0;
        start_op_i    = 2'b00;
        start_len_i   = 5'd0;
        in_valid_i    = 1'b0;
        in_data_i     = '0;
        out_ready_i   = 1'b0;

        repeat (2) @(negedge clk_i);
        chk_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Sum of four 1.0 back-to-back.
        start_cmd(2'b00, 5'd4);
        chk("sum4 busy", 32'(busy_o), 32'd1);
        chk("sum4 start_ready", 32'(start_ready_o), 32'd0);
        push(FP_ONE);
        push(FP_ONE);
        push(FP_ONE);
        chk("sum4 no early valid", 32'(out_valid_o), 32'd0);
        push(FP_ONE);
        chk("sum4 valid", 32'(out_valid_o), 32'd1);
        chk("sum4 data", 32'(out_data_o), 32'(FP_FOUR));
        chk("sum4 in_ready", 32'(in_ready_o), 32'd0);
        take();

        // Max over {1.0, -3.0, 2.0} with a bubble in the middle.
        start_cmd(2'b01, 5'd3);
        push(FP_ONE);
        push(FP_M3);
        @(negedge clk_i);
        chk("max bubble no valid", 32'(out_valid_o), 32'd0);
        push(FP_TWO);
        chk("max valid", 32'(out_valid_o), 32'd1);
        chk("max data", 32'(out_data_o), 32'(FP_TWO));
        take();

        // Min over the same stream.
        start_cmd(2'b10, 5'd3);
        push(FP_ONE);
        push(FP_M3);
        push(FP_TWO);
        chk("min valid", 32'(out_valid_o), 32'd1);
        chk("min data", 32'(out_data_o), 32'(FP_M3));
        take();

        // Op 11 behaves as sum: 1.0 + 2.0.
        start_cmd(2'b11, 5'd2);
        push(FP_ONE);
        push(FP_TWO);
        chk("op11 valid", 32'(out_valid_o), 32'd1);
        chk("op11 data", 32'(out_data_o), 32'(FP_THREE));
        take();

        // Zero-length command.
        start_cmd(2'b00, 5'd0);
        chk("len0 valid", 32'(out_valid_o), 32'd1);
        chk("len0 data", 32'(out_data_o), 32'd0);
        chk("len0 in_ready", 32'(in_ready_o), 32'd0);
        take();

        // Length 31 clamps to 16; offer 20 elements, count acceptances.
        start_cmd(2'b00, 5'd31);
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = FP_ONE;
            if (in_ready_o) n_acc++;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        chk("len31 accepted", 32'(n_acc), 32'd16);
        chk("len31 in_ready", 32'(in_ready_o), 32'd0);
        chk("len31 valid", 32'(out_valid_o), 32'd1);
        chk("len31 data", 32'(out_data_o), 32'(FP_16));

        // Result held while out_ready_i stays low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall data", 32'(out_data_o), 32'(FP_16));
            chk("stall valid", 32'(out_valid_o), 32'd1);
            chk("stall start_ready", 32'(start_ready_o), 32'd0);
        end
        take();

        // Flush in ACCUM, colliding with an element handshake.
        start_cmd(2'b00, 5'd4);
        push(FP_ONE);
        push(FP_ONE);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = FP_ONE;
        @(negedge clk_i);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk_reset_outputs("flush");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("post flush out_valid", 32'(out_valid_o), 32'd0);
        end

        // Asynchronous reset mid-reduction.
        start_cmd(2'b00, 5'd4);
        push(FP_ONE);
        push(FP_TWO);
        #2 rst_ni = 1'b0;
        #1 chk_reset_outputs("async reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Block recovers after reset.
        start_cmd(2'b00, 5'd2);
        push(FP_TWO);
        push(FP_TWO);
        chk("recover valid", 32'(out_valid_o), 32'd1);
        chk("recover data", 32'(out_data_o), 32'(FP_FOUR));
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
